rr_decode_arbiter: RTL and testbench
====================================

// Module: rr_decode_arbiter
// PURPOSE
//   Round-robin arbiter that shares one resource between 8 requesters and drives the
//   select lines of the 3-to-8 decoder that enables the winner. Outputs both the
//   3-bit grant index (decoder select) and the decoded one-hot grant.
//   Enforces break-before-make: one all-zero cycle between consecutive grants.
//   Optional hold timeout stops one requester from monopolising the resource.
// PARAMETERS
//   MAX_HOLD   16   max cycles a grant is held; 0 = no timeout
//   CNT_W      $clog2(MAX_HOLD+1) (min 1)   hold-counter width; derived, do not override
// PORTS
//   clk        input   1   single clock; all state updates on rising edge
//   rst        input   1   synchronous, active-high reset
//   req        input   8   request lines; req[i]=1 means requester i wants the resource
//   done       input   1   current owner releases the resource; sampled only in GRANT
//   gnt_idx    output  3   index of current owner (decoder select), registered
//   gnt        output  8   one-hot grant = decode(gnt_idx) when gnt_valid, else 8'h00
//   gnt_valid  output  1   1 while a grant is active
//   timeout    output  1   one-cycle pulse: the previous grant was force-released by MAX_HOLD
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//     last-grant pointer=7 (so req[0] has top priority first), hold counter=0.
//     Reset mid-grant: grant drops at that edge, no timeout pulse.
//   States: IDLE, GRANT, GAP. All outputs registered.
//   Arbitration (in IDLE and GAP): search req from (last+1) mod 8 upward, wrapping 7->0;
//     first set bit wins. If any req set: next edge -> GRANT, gnt_idx=winner,
//     gnt=1<<winner, gnt_valid=1, hold counter=0. If none: IDLE.
//   Latency: req sampled 1 at edge t (resource idle) -> gnt visible after edge t.
//   GRANT: no preemption; other req bits ignored. Release at an edge when any of:
//     (a) done=1, (b) req[gnt_idx]=0, (c) MAX_HOLD!=0 and counter==MAX_HOLD-1.
//     On release: gnt=0, gnt_valid=0, last=gnt_idx, state=GAP.
//     timeout=1 in GAP only if release came from (c) alone; (a) or (b) in the same
//     cycle as (c) takes priority -> timeout=0. Otherwise counter increments.
//   GAP: exactly one cycle with gnt=0; arbitrates as IDLE, so back-to-back grants are
//     separated by exactly one zero cycle. timeout clears after one cycle.
//   Invariant: gnt is 8'h00 or exactly one-hot and equals decode(gnt_idx) when valid.
//   done outside GRANT is ignored. gnt_idx keeps its last value when gnt_valid=0.
// TESTING
//   1 rst 2 cycles, req=8'h00 -> gnt=0, gnt_valid=0, timeout=0; req=8'h01 -> next cycle
//     gnt=8'h01, gnt_idx=0.
//   2 req=8'hFF held, done pulsed in every grant cycle -> gnt_idx sequence 0,1,..,7,0 with
//     one gnt=8'h00 cycle between each grant.
//   3 wrap: grant idx 5 released, req=8'h21 -> next grant idx 0 (search 6,7,0), not 5.
//   4 MAX_HOLD=4, req=8'h08 held, done=0 -> gnt=8'h08 for 4 cycles, 1 zero cycle with
//     timeout=1, then gnt=8'h08 again.
//   5 MAX_HOLD=4, done=1 on 4th grant cycle -> release, timeout stays 0; req[i] dropped
//     mid-grant -> gnt=0 next edge, timeout=0.
//   6 rst asserted during GRANT of idx 3 -> gnt=0 next edge; after rst, req=8'h18 -> idx 3
//     (pointer back to 7), not 4.

Source files
------------

// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bundle between requesters and the round-robin decode arbiter
//
// Purpose: groups the request, release and grant signals of rr_decode_arbiter.
// Signals:
//   req        8  request lines, req[i]=1 means requester i wants the resource
//   done       1  current owner releases the resource
//   gnt_idx    3  index of current owner (decoder select)
//   gnt        8  one-hot grant, 8'h00 when no grant is active
//   gnt_valid  1  a grant is active
//   timeout    1  one-cycle pulse after a hold-limit forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 8-way round-robin arbiter driving a 3-to-8 decoder with break-before-make
//
// Purpose: shares one resource between 8 requesters. The winner is granted until it
//   signals done, drops its request, or (MAX_HOLD != 0) holds for MAX_HOLD cycles.
//   Every release is followed by exactly one all-zero grant cycle.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of rr_decode_arbiter_if (req/done in, gnt_idx/gnt/gnt_valid/timeout out)
// Parameters:
//   MAX_HOLD  max cycles a grant is held, 0 disables the hold limit
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decode_arbiter_if.slave   bus
);

  localparam int                CNT_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       r_last;
  logic [2:0]       r_gnt_idx;
  logic [7:0]       r_gnt;
  logic             r_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_last_nxt;
  logic [2:0]       w_gnt_idx_nxt;
  logic [7:0]       w_gnt_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_any;
  logic [2:0]       w_winner;
  logic             w_hold_hit;
  logic             w_user_rel;
  logic             w_release;

  // Rotating priority search starting just after the last owner. The index
  // sum is 3 bits wide so it wraps 7->0 on its own; i=8 lands back on r_last,
  // which makes the previous owner the lowest priority candidate.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_last;
    for (int i = 1; i <= 8; i++) begin
      if (!w_any && bus.req[r_last + 3'(i)]) begin
        w_any    = 1'b1;
        w_winner = r_last + 3'(i);
      end
    end
  end

  assign w_hold_hit = HOLD_EN && (r_cnt == HOLD_LAST);
  assign w_user_rel = bus.done | ~bus.req[r_gnt_idx];
  assign w_release  = w_user_rel | w_hold_hit;

  // State register together with the registered outputs it produces.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 3'd7;
      r_gnt_idx <= 3'd0;
      r_gnt     <= 8'h00;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state logic. GAP arbitrates exactly like IDLE; the one-cycle gap
  // comes from GRANT never going straight back to GRANT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_GAP: w_state_nxt = w_any ? S_GRANT : S_IDLE;
      S_GRANT:       w_state_nxt = w_release ? S_GAP : S_GRANT;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_last_nxt    = r_last;
    w_gnt_idx_nxt = r_gnt_idx;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any) begin
          w_gnt_idx_nxt = w_winner;
          w_valid_nxt   = 1'b1;
          w_cnt_nxt     = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_last_nxt    = r_gnt_idx;
          // A voluntary release in the same cycle as the hold limit is not a timeout.
          w_timeout_nxt = w_hold_hit & ~w_user_rel;
        end else begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
    w_gnt_nxt = w_valid_nxt ? (8'h01 << w_gnt_idx_nxt) : 8'h00;
  end

  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - directed-vector bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  rr_decode_arbiter_if bus_a ();
  rr_decode_arbiter_if bus_b ();

  // Instance a has a 4-cycle hold limit, instance b has none; both see the same stimulus.
  rr_decode_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  rr_decode_arbiter #(.MAX_HOLD(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  assign bus_b.req  = bus_a.req;
  assign bus_b.done = bus_a.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic to);
    chk({tag, "_gnt"},   32'(bus_a.gnt),       32'(g));
    chk({tag, "_valid"}, 32'(bus_a.gnt_valid), 32'(g != 8'h00));
    chk({tag, "_idx"},   32'(bus_a.gnt_idx),   32'(idx));
    chk({tag, "_to"},    32'(bus_a.timeout),   32'(to));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.req  = 8'h00;
    bus_a.done = 1'b0;

    // Reset state and first grant latency
    tick;
    tick;
    chk_a("rst", 8'h00, 3'd0, 1'b0);
    chk("rst_b_gnt", 32'(bus_b.gnt), 32'h00);
    rst = 1'b0;
    tick;
    chk_a("idle", 8'h00, 3'd0, 1'b0);
    bus_a.req = 8'h01;
    tick;
    chk_a("t1_grant", 8'h01, 3'd0, 1'b0);
    bus_a.req = 8'h00;
    tick;
    chk_a("t1_drop", 8'h00, 3'd0, 1'b0);

    // Full rotation with done held high: 0..7,0 each followed by a zero cycle
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus_a.req  = 8'hFF;
    bus_a.done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick;
      chk_a($sformatf("t2_g%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b0);
      tick;
      chk_a($sformatf("t2_gap%0d", k), 8'h00, 3'(k % 8), 1'b0);
    end
    bus_a.req  = 8'h00;
    bus_a.done = 1'b0;

    // Wrap: after idx 5, req=8'h21 goes to 0 (search 6,7,0)
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus_a.req = 8'h20;
    tick;
    chk_a("t3_g5", 8'h20, 3'd5, 1'b0);
    bus_a.req  = 8'h21;
    bus_a.done = 1'b1;
    tick;
    chk_a("t3_gap", 8'h00, 3'd5, 1'b0);
    tick;
    chk_a("t3_wrap", 8'h01, 3'd0, 1'b0);
    bus_a.req  = 8'h00;
    bus_a.done = 1'b0;
    tick;
    chk_a("t3_rel", 8'h00, 3'd0, 1'b0);

    // Hold limit: 4 grant cycles, one zero cycle with timeout, regrant
    bus_a.req = 8'h08;
    tick;
    chk_a("t4_c1", 8'h08, 3'd3, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick;
      chk_a($sformatf("t4_c%0d", k), 8'h08, 3'd3, 1'b0);
    end
    tick;
    chk_a("t4_to", 8'h00, 3'd3, 1'b1);
    chk("t4_b_gnt", 32'(bus_b.gnt), 32'h08);
    chk("t4_b_to", 32'(bus_b.timeout), 32'h0);
    tick;
    chk_a("t4_regrant", 8'h08, 3'd3, 1'b0);

    // done on the 4th cycle wins over the hold limit; dropped req releases
    for (int k = 2; k <= 4; k++) begin
      tick;
      chk_a($sformatf("t5_c%0d", k), 8'h08, 3'd3, 1'b0);
    end
    bus_a.done = 1'b1;
    tick;
    chk_a("t5_done", 8'h00, 3'd3, 1'b0);
    chk("t5_b_gnt", 32'(bus_b.gnt), 32'h00);
    bus_a.done = 1'b0;
    tick;
    chk_a("t5_g", 8'h08, 3'd3, 1'b0);
    tick;
    chk_a("t5_c2", 8'h08, 3'd3, 1'b0);
    bus_a.req = 8'h00;
    tick;
    chk_a("t5_drop", 8'h00, 3'd3, 1'b0);

    // Reset mid-grant restores the pointer to 7
    bus_a.req = 8'h08;
    tick;
    chk_a("t6_g3", 8'h08, 3'd3, 1'b0);
    rst = 1'b1;
    tick;
    chk_a("t6_rst", 8'h00, 3'd0, 1'b0);
    chk("t6_b_gnt", 32'(bus_b.gnt), 32'h00);
    rst = 1'b0;
    bus_a.req = 8'h18;
    tick;
    chk_a("t6_ptr", 8'h08, 3'd3, 1'b0);
    chk("t6_b_idx", 32'(bus_b.gnt_idx), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
